// File: rtl/counter_monitor.sv
// Watches an external up/down/load counter and predicts its next value.
// Once locked, any sample that disagrees with the prediction is counted as an error.
module counter_monitor #(
  parameter int WIDTH = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic {UNSYNC, TRACK} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] prediction;
  logic             mismatch;
  logic             pulse_next;
  logic             sticky_next;
  logic [ERR_W-1:0] count_next;
  logic [WIDTH-1:0] expected_next;

  // Value the counter should show on the next enabled sample.
  always_comb begin
    prediction = q;
    case (mode)
      2'b00:   prediction = q;
      2'b01:   prediction = q + 1'b1;
      2'b10:   prediction = q - 1'b1;
      default: prediction = d;
    endcase
  end

  assign mismatch = (state == TRACK) && enable && (q != expected);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= UNSYNC;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      expected   <= '0;
    end else begin
      state      <= state_next;
      locked     <= (state_next == TRACK);
      err_pulse  <= pulse_next;
      err_sticky <= sticky_next;
      err_count  <= count_next;
      expected   <= expected_next;
    end
  end

  // Any gap in valid samples loses lock, since the counter may have moved unseen.
  always_comb begin
    state_next = state;
    if (clear || !enable) begin
      state_next = UNSYNC;
    end else begin
      state_next = TRACK;
    end
  end

  // A mismatch still resyncs expected from the observed q, so one glitch flags once.
  always_comb begin
    pulse_next    = 1'b0;
    sticky_next   = err_sticky;
    count_next    = err_count;
    expected_next = expected;
    if (clear) begin
      sticky_next = 1'b0;
      count_next  = '0;
    end else if (enable) begin
      expected_next = prediction;
      if (mismatch) begin
        pulse_next  = 1'b1;
        sticky_next = 1'b1;
        if (err_count != ERR_MAX) begin
          count_next = err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Randomised and directed bench for counter_monitor, checked every cycle
// against a rule-level model of lock, prediction and error bookkeeping.
module tb_counter_monitor;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] q;
  logic [1:0]  mode;
  logic [15:0] d;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic [15:0] expected;

  int checks   = 0;
  int failures = 0;

  int m_exp;
  int m_count;
  bit m_synced;
  bit m_pulse;
  bit m_sticky;

  counter_monitor #(.WIDTH(16), .ERR_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .q(q),
    .mode(mode),
    .d(d),
    .clear(clear),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_sticky(err_sticky),
    .err_count(err_count),
    .expected(expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int predict(input int qv, input int mv, input int dv);
    case (mv)
      0:       return qv;
      1:       return (qv + 1) % 65536;
      2:       return (qv + 65535) % 65536;
      default: return dv;
    endcase
  endfunction

  // Reference behaviour: lock on the first valid sample, then count disagreements.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_exp    = 0;
      m_count  = 0;
      m_synced = 0;
      m_pulse  = 0;
      m_sticky = 0;
    end else if (clear) begin
      m_synced = 0;
      m_pulse  = 0;
      m_sticky = 0;
      m_count  = 0;
    end else if (!enable) begin
      m_synced = 0;
      m_pulse  = 0;
    end else begin
      m_pulse = m_synced && (int'(q) != m_exp);
      if (m_pulse) begin
        m_sticky = 1;
        if (m_count < 255) m_count = m_count + 1;
      end
      m_exp    = predict(int'(q), int'(mode), int'(d));
      m_synced = 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int want);
    checks = checks + 1;
    if (actual != want) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, actual, want, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("locked", int'(locked), int'(m_synced));
    checkOutput("err_pulse", int'(err_pulse), int'(m_pulse));
    checkOutput("err_sticky", int'(err_sticky), int'(m_sticky));
    checkOutput("err_count", int'(err_count), m_count);
    checkOutput("expected", int'(expected), m_exp);
  end

  task automatic applyStimulus(input bit en, input int mv, input int qv, input int dv, input bit clr);
    enable = en;
    mode   = 2'(mv);
    q      = 16'(qv);
    d      = 16'(dv);
    clear  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_locked"}, int'(locked), 0);
    checkOutput({tag, "_pulse"}, int'(err_pulse), 0);
    checkOutput({tag, "_sticky"}, int'(err_sticky), 0);
    checkOutput({tag, "_count"}, int'(err_count), 0);
    checkOutput({tag, "_expected"}, int'(expected), 0);
  endtask

  // Reset asserted and released between clock edges.
  task automatic midCycleReset(input string tag);
    #2 reset_n = 1'b0;
    #1 checkAllZero({tag, "_async"});
    #4 reset_n = 1'b1;
    #1 checkAllZero({tag, "_release"});
  endtask

  initial begin
    int qv;
    reset_n = 1'b0;
    enable  = 1'b0;
    mode    = 2'b00;
    q       = '0;
    d       = '0;
    clear   = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    #1 checkAllZero("pre_edge");
    @(posedge clk);
    #1;

    $display("[TB] up-count lock");
    for (int i = 0; i <= 20; i++) begin
      applyStimulus(1, 1, i, 0, 0);
      if (i == 0) checkOutput("lock_2nd_cycle", int'(locked), 1);
    end
    checkOutput("up_count_errs", int'(err_count), 0);
    checkOutput("up_expected", int'(expected), 21);

    $display("[TB] wrap-around");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 16'hFFFE, 0, 0);
    applyStimulus(1, 1, 16'hFFFF, 0, 0);
    checkOutput("wrap_up_expected", int'(expected), 0);
    applyStimulus(1, 1, 16'h0000, 0, 0);
    applyStimulus(1, 2, 16'h0001, 0, 0);
    applyStimulus(1, 2, 16'h0000, 0, 0);
    checkOutput("wrap_down_expected", int'(expected), 16'hFFFF);
    applyStimulus(1, 2, 16'hFFFF, 0, 0);
    checkOutput("wrap_errs", int'(err_count), 0);

    $display("[TB] single glitch");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 0, 0);
    applyStimulus(1, 1, 6, 0, 0);
    checkOutput("glitch_pre_pulse", int'(err_pulse), 0);
    applyStimulus(1, 1, 9, 0, 0);
    checkOutput("glitch_pulse", int'(err_pulse), 1);
    checkOutput("glitch_count", int'(err_count), 1);
    checkOutput("glitch_sticky", int'(err_sticky), 1);
    applyStimulus(1, 1, 10, 0, 0);
    checkOutput("glitch_resync_pulse", int'(err_pulse), 0);
    checkOutput("glitch_resync_count", int'(err_count), 1);

    $display("[TB] load prediction");
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 3, 7, 16'h1234, 0);
    applyStimulus(1, 0, 16'h1234, 0, 0);
    checkOutput("load_ok_count", int'(err_count), 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 3, 7, 16'h1234, 0);
    applyStimulus(1, 0, 16'h1235, 0, 0);
    checkOutput("load_bad_count", int'(err_count), 1);

    $display("[TB] saturation and clear");
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("sat_count", int'(err_count), 255);
    checkOutput("sat_pulse", int'(err_pulse), 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("clr_count", int'(err_count), 0);
    checkOutput("clr_sticky", int'(err_sticky), 0);
    checkOutput("clr_pulse", int'(err_pulse), 0);
    checkOutput("clr_locked", int'(locked), 0);

    $display("[TB] async reset while locked");
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("pre_rst_count", int'(err_count), 3);
    checkOutput("pre_rst_locked", int'(locked), 1);
    midCycleReset("rst_locked");
    applyStimulus(1, 1, 100, 0, 0);
    checkOutput("post_rst_pulse", int'(err_pulse), 0);
    checkOutput("post_rst_expected", int'(expected), 101);

    $display("[TB] enable gap");
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("gap_locked", int'(locked), 0);
    checkOutput("gap_count", int'(err_count), 2);
    checkOutput("gap_expected", int'(expected), 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) midCycleReset("rand_rst");
      case ($urandom_range(0, 9))
        0, 1:    qv = int'($urandom_range(0, 65535));
        2:       qv = ($urandom_range(0, 1) == 0) ? 0 : 65535;
        default: qv = m_exp;
      endcase
      applyStimulus(($urandom_range(0, 19) != 0), int'($urandom_range(0, 3)), qv,
                    int'($urandom_range(0, 65535)), ($urandom_range(0, 39) == 0));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
